// File: rtl/clk_div_monitor_if.sv
// Handshake-free bundle between a divided-clock source and its monitor.
// Source drives div_clk/times; the monitor returns strobes and status.
interface clk_div_monitor_if #(
  parameter int CNT_W = 16
);
  logic             div_clk;
  int               times;
  logic             rise_stb;
  logic             fall_stb;
  logic [CNT_W-1:0] period;
  logic             locked;
  logic             err;
  logic             err_seen;

  modport master (
    output div_clk, times,
    input  rise_stb, fall_stb, period, locked, err, err_seen
  );

  modport slave (
    input  div_clk, times,
    output rise_stb, fall_stb, period, locked, err, err_seen
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Samples a divided clock as data, emits edge strobes, tracks its period.
// Optional input synchronizer enabled by defining CLK_DIV_MON_SYNC_EN.
module clk_div_monitor #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1
) (
  input logic               clk,
  input logic               reset,
  clk_div_monitor_if.slave  bus
);
  localparam int MC_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCK
  } state_t;

  logic r_s;

`ifdef CLK_DIV_MON_SYNC_EN
  logic r_sync1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_sync1 <= bus.div_clk;
      r_s     <= r_sync1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) r_s <= 1'b0;
    else       r_s <= bus.div_clk;
  end
`endif

  logic r_d;
  logic r_rise_det;
  logic r_fall_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d        <= 1'b0;
      r_rise_det <= 1'b0;
      r_fall_det <= 1'b0;
    end else begin
      r_d        <= r_s;
      r_rise_det <= r_s & ~r_d;
      r_fall_det <= ~r_s & r_d;
    end
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [MC_W-1:0]  r_mcnt;
  logic [CNT_W-1:0] r_period;
  logic             r_rise_stb;
  logic             r_fall_stb;
  logic             r_locked;
  logic             r_err;
  logic             r_err_seen;

  logic [CNT_W-1:0] w_pnew;
  logic [31:0]      w_p32;
  logic [31:0]      w_t;
  logic [31:0]      w_diff;
  logic             w_match;
  logic             w_tmo;
  logic             w_inv;
  logic             w_ev;

  assign w_ev    = r_rise_det;
  assign w_pnew  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_p32   = 32'(w_pnew);
  assign w_t     = bus.times;
  assign w_diff  = (w_p32 >= w_t) ? (w_p32 - w_t) : (w_t - w_p32);
  assign w_match = w_diff <= 32'(TOL);
  assign w_tmo   = {1'b0, 32'(r_cnt)} >= {w_t, 1'b0};
  assign w_inv   = bus.times < 2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mcnt     <= '0;
      r_period   <= '0;
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_seen <= 1'b0;
    end else begin
      r_rise_stb <= r_rise_det;
      r_fall_stb <= r_fall_det;
      r_err      <= 1'b0;

      if (w_ev) begin
        r_period <= w_pnew;
        r_cnt    <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A rise in the same cycle as a timeout takes precedence
      if (w_inv) begin
        r_state  <= S_IDLE;
        r_mcnt   <= '0;
        r_locked <= 1'b0;
      end else if (w_ev) begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ACQ;
            r_mcnt  <= '0;
          end
          S_ACQ: begin
            if (!w_match) begin
              r_mcnt <= '0;
            end else if (r_mcnt == MC_W'(LOCK_CNT - 1)) begin
              r_state  <= S_LOCK;
              r_locked <= 1'b1;
              r_mcnt   <= '0;
            end else begin
              r_mcnt <= r_mcnt + 1'b1;
            end
          end
          S_LOCK: begin
            if (!w_match) begin
              r_state    <= S_ACQ;
              r_locked   <= 1'b0;
              r_mcnt     <= '0;
              r_err      <= 1'b1;
              r_err_seen <= 1'b1;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
            r_mcnt   <= '0;
          end
        endcase
      end else if (w_tmo) begin
        case (r_state)
          S_ACQ: begin
            r_state <= S_IDLE;
            r_mcnt  <= '0;
          end
          S_LOCK: begin
            r_state    <= S_IDLE;
            r_locked   <= 1'b0;
            r_mcnt     <= '0;
            r_err      <= 1'b1;
            r_err_seen <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rise_stb = r_rise_stb;
  assign bus.fall_stb = r_fall_stb;
  assign bus.period   = r_period;
  assign bus.locked   = r_locked;
  assign bus.err      = r_err;
  assign bus.err_seen = r_err_seen;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: table of waveform phases plus
// hand-written reset, stopped-clock and latency sequences.
module tb_clk_div_monitor;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  clk_div_monitor_if #(.CNT_W(16)) bus ();

  clk_div_monitor #(
    .CNT_W   (16),
    .LOCK_CNT(4),
    .TOL     (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

`ifdef CLK_DIV_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int times;
    int hi;
    int lo;
    int n;
    int e_per;
    int e_lk;
    int e_err;
    int e_seen;
  } vec_t;

  vec_t tv[12];

  int n_chk = 0;
  int n_err = 0;
  int g_cyc = 0;
  int v_rise;
  int v_err;
  int last_rise;
  int first_err;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v);
    bus.div_clk = v;
    @(posedge clk);
    #1;
    g_cyc++;
    if (bus.rise_stb) begin
      v_rise++;
      last_rise = g_cyc;
    end
    if (bus.err) begin
      v_err++;
      if (first_err < 0) first_err = g_cyc;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int h = 0; h < hi; h++) cyc(1'b1);
      for (int l = 0; l < lo; l++) cyc(1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rise_stb"}, int'(bus.rise_stb), 0);
    chk({tag, " fall_stb"}, int'(bus.fall_stb), 0);
    chk({tag, " period"}, int'(bus.period), 0);
    chk({tag, " locked"}, int'(bus.locked), 0);
    chk({tag, " err"}, int'(bus.err), 0);
    chk({tag, " err_seen"}, int'(bus.err_seen), 0);
  endtask

  initial begin
    int n;
    // times hi lo n | period locked errs err_seen
    tv[0]  = '{8, 4, 4, 4, 8, 0, 0, 0};
    tv[1]  = '{8, 4, 4, 1, 8, 1, 0, 0};
    tv[2]  = '{8, 4, 3, 2, 7, 1, 0, 0};
    tv[3]  = '{8, 4, 5, 2, 9, 1, 0, 0};
    tv[4]  = '{8, 5, 5, 1, 9, 1, 0, 0};
    tv[5]  = '{8, 4, 4, 1, 10, 0, 1, 1};
    tv[6]  = '{8, 4, 4, 3, 8, 0, 0, 1};
    tv[7]  = '{8, 4, 4, 1, 8, 1, 0, 1};
    tv[8]  = '{1, 3, 2, 3, 5, 0, 0, 1};
    tv[9]  = '{8, 4, 4, 5, 8, 1, 0, 1};
    tv[10] = '{12, 4, 4, 1, 8, 0, 1, 1};
    tv[11] = '{8, 4, 4, 4, 8, 1, 0, 1};

    reset = 1'b1;
    bus.times = 8;
    v_rise = 0;
    v_err = 0;
    last_rise = 0;
    first_err = -1;
    repeat (3) cyc(1'b0);
    chk_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus.times = tv[i].times;
      v_rise = 0;
      v_err = 0;
      wave(tv[i].hi, tv[i].lo, tv[i].n);
      chk($sformatf("v%0d rises", i), v_rise, tv[i].n);
      chk($sformatf("v%0d period", i), int'(bus.period), tv[i].e_per);
      chk($sformatf("v%0d locked", i), int'(bus.locked), tv[i].e_lk);
      chk($sformatf("v%0d errs", i), v_err, tv[i].e_err);
      chk($sformatf("v%0d err_seen", i), int'(bus.err_seen), tv[i].e_seen);
    end

    // Reset while locked, then relock from scratch
    reset = 1'b1;
    cyc(1'b0);
    chk_zero("midreset");
    reset = 1'b0;
    v_rise = 0;
    wave(4, 4, 4);
    chk("relock 4 rises locked", int'(bus.locked), 0);
    wave(4, 4, 1);
    chk("relock 5 rises locked", int'(bus.locked), 1);
    chk("relock rises", v_rise, 5);
    chk("relock err_seen", int'(bus.err_seen), 0);

    // Stopped clock: cnt reaches 2*times sixteen cycles after the rise,
    // err is registered on the following edge
    v_err = 0;
    first_err = -1;
    repeat (40) cyc(1'b0);
    chk("stop errs", v_err, 1);
    chk("stop err offset", first_err - last_rise, 2 * 8 + 1);
    chk("stop locked", int'(bus.locked), 0);
    chk("stop err_seen", int'(bus.err_seen), 1);

    // Single step latency
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1);
      n++;
      if (bus.rise_stb) break;
    end
    chk("rise latency", n, LAT + 1);
    cyc(1'b1);
    chk("rise one cycle", int'(bus.rise_stb), 0);
    repeat (5) cyc(1'b1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0);
      n++;
      if (bus.fall_stb) break;
    end
    chk("fall latency", n, LAT + 1);
    cyc(1'b0);
    chk("fall one cycle", int'(bus.fall_stb), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
